data_cache_ctrl: RTL

Direct-mapped, write-through, no-write-allocate data cache with its miss/write controller. It sits between the single-cycle core's memory stage and main memory. It responds to the `mem_read`/`mem_write` strobes produced by instruction decode, and freezes the core through `stall` while it runs block fills and write-throughs over a request/response handshake to main memory.

---
 rtl/data_cache_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache with its
// block-fill / write-through controller toward main memory.
module data_cache_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              mm_req,
    output logic              mm_we,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [31:0]       mm_wdata,
    input  logic [31:0]       mm_rdata,
    input  logic              mm_rvalid,
    input  logic              mm_ack
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = LINES << OFFSET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e              state_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q  [LINES];
    logic [31:0]         data_q [WORDS];
    logic [OFFSET_W-1:0] cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                req_q;
    logic                we_q;

    logic [ADDR_W-1:0]   wa;
    logic [TAG_W-1:0]    tag_c;
    logic [INDEX_W-1:0]  index_c;
    logic [OFFSET_W-1:0] off_c;
    logic [TAG_W-1:0]    tag_l;
    logic [INDEX_W-1:0]  index_l;
    logic [OFFSET_W-1:0] off_l;
    logic                hit;
    logic                hit_l;
    logic                fill_we;
    logic                last_beat;
    logic                store_we;
    logic                unused_addr;

    assign wa      = addr[ADDR_W+1:2];
    assign tag_c   = wa[ADDR_W-1 -: TAG_W];
    assign index_c = wa[OFFSET_W +: INDEX_W];
    assign off_c   = wa[OFFSET_W-1:0];
    assign tag_l   = addr_q[ADDR_W-1 -: TAG_W];
    assign index_l = addr_q[OFFSET_W +: INDEX_W];
    assign off_l   = addr_q[OFFSET_W-1:0];

    assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

    assign hit   = valid_q[index_c] && (tag_q[index_c] == tag_c);
    assign hit_l = valid_q[index_l] && (tag_q[index_l] == tag_l);

    assign read_data = hit ? data_q[{index_c, off_c}] : 32'h0;

    assign fill_we   = !rst && (state_q == FILL) && mm_rvalid;
    assign last_beat = fill_we && (cnt_q == '1);
    assign store_we  = !rst && (state_q == WRITE) && mm_ack && hit_l;

    assign mm_req   = req_q;
    assign mm_we    = we_q;
    assign mm_addr  = addr_q;
    assign mm_wdata = wdata_q;

    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            IDLE:    stall = mem_write | (mem_read & ~hit);
            FILL:    stall = 1'b1;
            WRITE:   stall = ~mm_ack;
            default: stall = 1'b0;
        endcase
    end

    // Storage arrays carry no reset; valid_q alone decides whether they count.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[{index_l, cnt_q}] <= mm_rdata;
        end else if (store_we) begin
            data_q[{index_l, off_l}] <= wdata_q;
        end
        if (last_beat) begin
            tag_q[index_l] <= tag_l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (mem_write) begin
                        addr_q  <= wa;
                        wdata_q <= write_data;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end else if (mem_read && !hit) begin
                        // The victim line is unusable until the last beat lands.
                        addr_q           <= {tag_c, index_c, {OFFSET_W{1'b0}}};
                        cnt_q            <= '0;
                        valid_q[index_c] <= 1'b0;
                        req_q            <= 1'b1;
                        we_q             <= 1'b0;
                        state_q          <= FILL;
                    end
                end
                FILL: begin
                    if (mm_rvalid) begin
                        cnt_q <= cnt_q + OFFSET_W'(1);
                        if (cnt_q == '1) begin
                            valid_q[index_l] <= 1'b1;
                            req_q            <= 1'b0;
                            state_q          <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mm_ack) begin
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
